// File: rtl/pipe_pkg.sv
// pipe_pkg: constants, types and helpers shared by the elastic pipeline chain.
//   MAX_STAGES   : largest supported chain depth
//   stat_cnt_t   : width of the statistics counters
//   clog2()      : width helper used to size the occupancy count
package pipe_pkg;

  localparam int MAX_STAGES = 8;

  typedef logic [15:0] stat_cnt_t;

  localparam stat_cnt_t STAT_CNT_MAX = 16'hFFFF;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// pipe_stage_cell: one register stage of the elastic chain.
// Ports:
//   clk_i, rst_n_i   clock / async active-low reset
//   load_en_i        stage may take the upstream beat this edge
//   clr_i            invalidate the stage and reload RESET_DATA
//   up_valid_i       upstream stage (or chain input) holds a beat
//   up_data_i        upstream payload
//   valid_o, data_o  registered stage contents
module pipe_stage_cell #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_en_i,
  input  logic              clr_i,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= RESET_DATA;
    end else if (clr_i) begin
      valid_o <= 1'b0;
      data_o  <= RESET_DATA;
    end else if (load_en_i) begin
      valid_o <= up_valid_i;
      // A bubble moving in leaves the old payload in place.
      if (up_valid_i) data_o <= up_data_i;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic chain of STAGES registers with valid/ready at both
// ends. Empty stages collapse so bubbles are squeezed out; stall freezes the
// chain, flush empties it (stall has priority).
// Ports:
//   clk_i, rst_n_i                     clock / async active-low reset
//   in_valid_i, in_ready_o, in_data_i  upstream handshake and payload
//   out_valid_o, out_ready_i, out_data_o downstream handshake and payload
//   stall_i, flush_i                   global freeze / invalidate
//   occ_o, bp_cnt_o                    occupancy and backpressure counters
// Optional feature macro: PIPE_STATS_EN adds occ_o / bp_cnt_o and their logic.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                STAGES     = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_W-1:0]             out_data_o,
  input  logic                          stall_i,
  input  logic                          flush_i
`ifdef PIPE_STATS_EN
  ,
  output logic [clog2(STAGES+1)-1:0]    occ_o,
  output stat_cnt_t                     bp_cnt_o
`endif
);

  logic [STAGES:0]    rdy;
  logic [STAGES-1:0]  v;
  logic [STAGES-1:0]  up_v;
  logic [DATA_W-1:0]  d    [STAGES];
  logic [DATA_W-1:0]  up_d [STAGES];
  logic               adv;
  logic               clr;

  assign adv = ~stall_i & ~flush_i;
  assign clr = flush_i & ~stall_i;

  // A stage can take a beat if it is empty or everything in front of it moves;
  // out_ready_i ripples all the way back in the same cycle.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid_i;
    up_d[0] = in_data_i;
    for (int k = 1; k < STAGES; k++) begin
      up_v[k] = v[k-1];
      up_d[k] = d[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_stage_cell #(
      .DATA_W     (DATA_W),
      .RESET_DATA (RESET_DATA)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_en_i  (adv & rdy[k]),
      .clr_i      (clr),
      .up_valid_i (up_v[k]),
      .up_data_i  (up_d[k]),
      .valid_o    (v[k]),
      .data_o     (d[k])
    );
  end

  assign in_ready_o  = rdy[0] & ~stall_i;
  assign out_valid_o = v[STAGES-1] & ~stall_i;
  assign out_data_o  = d[STAGES-1];

`ifdef PIPE_STATS_EN
  localparam int OCC_W = clog2(STAGES + 1);

  logic [OCC_W-1:0] occ_nxt;

  // Count the valid bits the stages will hold after this edge, so occ_o
  // always matches the current stage contents.
  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (!clr) begin
        if (adv && rdy[k]) occ_nxt = occ_nxt + OCC_W'(up_v[k]);
        else               occ_nxt = occ_nxt + OCC_W'(v[k]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_o    <= '0;
      bp_cnt_o <= '0;
    end else begin
      occ_o <= occ_nxt;
      if (out_valid_o && !out_ready_i && bp_cnt_o != STAT_CNT_MAX)
        bp_cnt_o <= bp_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised, elastic successor to the fixed IF_ID/ID_EX/EX_MEM/MEM_WB pipeline registers. A chain of STAGES data registers, each DATA_W wide, with per-stage valid bits and a valid/ready handshake on both ends. Empty stages collapse, so bubbles are squeezed out. Global stall and flush controls match the existing pipeline semantics. Intended for new CPU datapath stages and for the D-cache request/response paths.

Parameters:
DATA_W, 32, payload width in bits (1..256)
STAGES, 1, number of register stages (1..8)
RESET_DATA, 0, value loaded into every data register on reset and on flush

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  chain can accept a beat
in_data_i  in  DATA_W  upstream payload
out_valid_o  out  1  last stage holds a valid beat
out_ready_i  in  1  downstream accepts the beat
out_data_o  out  DATA_W  last-stage payload
stall_i  in  1  freeze the whole chain
flush_i  in  1  invalidate every stage
occ_o  out  $clog2(STAGES+1)  valid-stage count (PIPE_STATS_EN only)
bp_cnt_o  out  16  backpressure cycle count (PIPE_STATS_EN only)

Behaviour:
- Reset (rst_n_i=0, asynchronous): all v[k]=0; all d[k]=RESET_DATA; out_valid_o=0; out_data_o=RESET_DATA; stats counters=0. Reset during traffic drops all beats immediately.
- Ready chain (combinational): rdy[STAGES]=out_ready_i; rdy[k]=~v[k] | rdy[k+1]; in_ready_o=rdy[0] & ~stall_i.
- out_valid_o=v[STAGES-1] & ~stall_i; out_data_o=d[STAGES-1].
- Each clock, when stall_i=0 and flush_i=0, for stage k with rdy[k]=1:
  - v[k] <= upstream valid (in_valid_i for k=0, v[k-1] otherwise).
  - d[k] loads only when the upstream valid is 1; otherwise it holds.
- Stages with rdy[k]=0 hold both v and d.
- Latency: STAGES cycles from input handshake to out_valid_o with no backpressure. Throughput: 1 beat/cycle sustained.
- Full: all v=1 and out_ready_i=0 -> in_ready_o=0. A single-cycle out_ready_i pulse then frees one slot in that same cycle (combinational pass-through).
- Empty: out_valid_o=0. out_data_o holds the last value.
- stall_i=1: no state changes; in_ready_o=0; out_valid_o=0; no handshake at either end.
- flush_i=1 (stall_i=0): next edge sets all v=0 and all d=RESET_DATA. An input beat presented in the same cycle is dropped, and in_ready_o is still reported per the ready chain.
- stall_i and flush_i both 1: stall wins and the flush is ignored. The hazard unit holds flush_i until stall_i drops.
- Payload ordering is strictly FIFO. No beat is duplicated or lost except on flush or reset.

Optional Feature:
PIPE_STATS_EN
- Defined:
  - occ_o = popcount(v), registered, updated every edge.
  - bp_cnt_o increments each cycle with out_valid_o=1 and out_ready_i=0, and saturates at 16'hFFFF.
  - Both counters are cleared by reset only; flush does not clear them.
- Undefined: occ_o and bp_cnt_o ports and their logic are absent. Core behaviour is unchanged.

Decomposition:
- Shared package pipe_pkg: MAX_STAGES=8 constant; the occupancy-width function clog2; a typedef for the stats counter (16-bit).
- Sub-module pipe_stage_cell: one stage (v/d registers, load enable from upstream valid and rdy), instantiated STAGES times via generate.
- The ready chain, stall/flush gating and stats logic live in the top level.

Test Plan:
- STAGES=3, DATA_W=32, out_ready_i=1; stream 0x11,0x22,0x33 on back-to-back cycles -> out_valid_o rises 3 cycles after the first handshake and emits 0x11,0x22,0x33 on consecutive cycles.
- STAGES=3; hold out_ready_i=0 and offer 5 beats -> in_ready_o=0 after 3 accepted. Raise out_ready_i -> 0x11..0x55 delivered in order, none lost.
- Bubble collapse, STAGES=4: one beat enters, out_ready_i=0 -> by cycle 4 the beat sits in stage 3 and occ_o=1 (PIPE_STATS_EN).
- stall_i=1 for 4 cycles with 2 beats in flight -> outputs and occupancy frozen, in_ready_o=0. On release the beats resume unchanged.
- flush_i=1 with 3 beats plus a simultaneous input 0xAA -> next cycle out_valid_o=0, out_data_o=RESET_DATA, and 0xAA is never output. stall_i=1 plus flush_i=1 -> the beats survive.
- Assert rst_n_i=0 mid-stream, off the clock edge -> out_valid_o=0 immediately. Under PIPE_STATS_EN, 70000 backpressured cycles -> bp_cnt_o=16'hFFFF.
